// File: rtl/exec_unit_dtypes.sv
// Shared types and helpers for the execution-unit result interconnect.
package exec_unit_dtypes;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Increment with explicit wrap so non-power-of-2 unit counts stay in range.
    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/eu_icon_rr_scan.sv
// Combinational scan: grants the first NUM_CHANNELS requesters found walking
// from the start index, and maps the k-th winner onto channel k.
module eu_icon_rr_scan
    import exec_unit_dtypes::*;
#(
    parameter int NUM_UNITS    = 4,
    parameter int NUM_CHANNELS = 2,
    localparam int UNIT_ID_W   = $clog2(NUM_UNITS)
) (
    input  logic [NUM_UNITS-1:0]                     req,
    input  logic [UNIT_ID_W-1:0]                     start,
    output logic [NUM_UNITS-1:0]                     grant,
    output logic [NUM_CHANNELS-1:0][UNIT_ID_W-1:0]   ch_unit,
    output logic [NUM_CHANNELS-1:0]                  ch_assigned,
    output logic [UNIT_ID_W-1:0]                     last_idx
);

    // Walk units in scan order, handing out channels until they run out.
    always_comb begin
        logic [UNIT_ID_W-1:0] idx;
        int cnt;
        grant       = '0;
        ch_unit     = '0;
        ch_assigned = '0;
        last_idx    = '0;
        cnt         = 0;
        idx         = start;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (req[idx] && cnt < NUM_CHANNELS) begin
                grant[idx] = 1'b1;
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    if (c == cnt) begin
                        ch_unit[c]     = idx;
                        ch_assigned[c] = 1'b1;
                    end
                end
                last_idx = idx;
                cnt++;
            end
            idx = UNIT_ID_W'(wrap_inc(32'(idx), NUM_UNITS));
        end
    end

endmodule

// File: rtl/eu_icon_arbiter.sv
// N-unit to M-channel broadcast arbiter: picks up to NUM_CHANNELS requesters
// per cycle and registers their payloads, tagged with source ID, onto channels.
module eu_icon_arbiter
    import exec_unit_dtypes::*;
#(
    parameter int NUM_UNITS    = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ARB_MODE     = 0,
    localparam int UNIT_ID_W   = $clog2(NUM_UNITS)
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     flush,
    input  logic [NUM_UNITS-1:0]                     req_valid,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]     req_data,
    output logic [NUM_UNITS-1:0]                     req_ready,
    output logic [NUM_CHANNELS-1:0]                  ch_valid,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  ch_data,
    output logic [NUM_CHANNELS-1:0][UNIT_ID_W-1:0]   ch_src,
    output logic [UNIT_ID_W-1:0]                     rr_ptr_o
);

    if (NUM_UNITS < 2 || NUM_CHANNELS < 1 || NUM_CHANNELS > NUM_UNITS) begin : g_bad_params
        $error("eu_icon_arbiter: need NUM_UNITS >= 2 and 1 <= NUM_CHANNELS <= NUM_UNITS");
    end

    localparam bit FIXED = (ARB_MODE == int'(ARB_FIXED));

    typedef struct packed {
        logic                  valid;
        logic [UNIT_ID_W-1:0]  src;
        logic [DATA_WIDTH-1:0] data;
    } ch_rec_t;

    ch_rec_t [NUM_CHANNELS-1:0]                ch_q, ch_d;
    logic [UNIT_ID_W-1:0]                      rr_ptr_q, rr_ptr_d;
    logic [UNIT_ID_W-1:0]                      scan_start;
    logic [UNIT_ID_W-1:0]                      last_idx;
    logic [NUM_UNITS-1:0]                      grant;
    logic [NUM_CHANNELS-1:0][UNIT_ID_W-1:0]    ch_unit;
    logic [NUM_CHANNELS-1:0]                   ch_assigned;

    assign scan_start = FIXED ? '0 : rr_ptr_q;

    eu_icon_rr_scan #(
        .NUM_UNITS    (NUM_UNITS),
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_scan (
        .req         (req_valid),
        .start       (scan_start),
        .grant       (grant),
        .ch_unit     (ch_unit),
        .ch_assigned (ch_assigned),
        .last_idx    (last_idx)
    );

    // Ready is suppressed during reset and flush so no transfer can slip through.
    assign req_ready = (reset_n && !flush) ? grant : '0;

    // Next state for pointer and channel registers; unassigned channels keep payload.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        ch_d     = ch_q;
        if (flush) begin
            rr_ptr_d = '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ch_d[c].valid = 1'b0;
            end
        end else begin
            if (FIXED) begin
                rr_ptr_d = '0;
            end else if (|grant) begin
                rr_ptr_d = UNIT_ID_W'(wrap_inc(32'(last_idx), NUM_UNITS));
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ch_d[c].valid = ch_assigned[c];
                if (ch_assigned[c]) begin
                    ch_d[c].src  = ch_unit[c];
                    ch_d[c].data = req_data[ch_unit[c]];
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            ch_q     <= ch_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Unpack channel records onto the output ports.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ch_valid[c] = ch_q[c].valid;
            ch_data[c]  = ch_q[c].data;
            ch_src[c]   = ch_q[c].src;
        end
        rr_ptr_o = rr_ptr_q;
    end

endmodule

// File: doc/eu_icon_arbiter.md
# eu_icon_arbiter

Parametrised N-unit to M-channel broadcast arbiter for the execution-unit result interconnect. Each cycle it picks up to NUM_CHANNELS requesting units, by round-robin or fixed priority, and accepts their payloads with a valid/ready handshake. Each winning payload is registered onto its own broadcast channel, tagged with the source unit ID. It sits between the execution units' result ports and the shared operand-forwarding channels, and replaces the unclocked interconnect stub with clocked arbitration and buffering.

## Interface
- NUM_UNITS, 4: number of requesting units; must be ≥ 2.
- NUM_CHANNELS, 2: number of broadcast channels; must be ≥ 1 and ≤ NUM_UNITS.
- DATA_WIDTH, 32: payload width.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (unit 0 highest).
- clk, input, 1: single clock; all state is updated on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous pipeline flush.
- req_valid, input, [NUM_UNITS]: unit i is offering a payload.
- req_data, input, [NUM_UNITS][DATA_WIDTH]: payload from each unit.
- req_ready, output, [NUM_UNITS]: unit i is granted this cycle; combinational.
- ch_valid, output, [NUM_CHANNELS]: channel c carries a valid broadcast.
- ch_data, output, [NUM_CHANNELS][DATA_WIDTH]: broadcast payload.
- ch_src, output, [NUM_CHANNELS][UNIT_ID_W]: ID of the source unit.
- rr_ptr_o, output, UNIT_ID_W: current scan start, for debug and coverage.

## Operation
- UNIT_ID_W = $clog2(NUM_UNITS).
- Scan start:
  - round-robin mode uses rr_ptr;
  - fixed mode always uses 0.
- Scan order: units rr_ptr, rr_ptr+1, … mod NUM_UNITS.
- Grant rule: the first min(NUM_CHANNELS, popcount(req_valid)) requesting units in scan order are granted.
- Channel assignment: the k-th granted unit in scan order goes to channel k. Channels above the grant count are idle next cycle.
- Handshake:
  - a transfer occurs when req_valid[i] && req_ready[i] are both high;
  - a unit holds req_valid and req_data stable until it is granted;
  - req_ready depends on req_valid, so a unit must not drive valid from ready.
- Pointer update, round-robin mode:
  - if any grant occurs, rr_ptr ← (index of the last granted unit + 1) mod NUM_UNITS, with explicit wrap when NUM_UNITS is not a power of 2;
  - if there are no grants, rr_ptr holds.
- Pointer update, fixed mode: rr_ptr stays 0.
- Output registers:
  - ch_valid[c] ← 1 if channel c was assigned, else 0;
  - ch_data and ch_src load only when assigned, otherwise they hold their previous value.
- flush = 1:
  - req_ready is forced to all 0 (no transfer);
  - ch_valid ← 0 next edge;
  - rr_ptr ← 0.
- Channels have no back-pressure; consumers must sample every cycle.
- Fairness: in round-robin mode, every continuously requesting unit is granted within ceil(NUM_UNITS/NUM_CHANNELS) cycles.

## Timing
- Request to broadcast latency: 1 cycle. A grant at edge n makes ch_valid high during cycle n+1.
- Throughput: up to NUM_CHANNELS transfers per cycle, sustained.
- Reset values (asynchronous): ch_valid = 0, ch_data = 0, ch_src = 0, rr_ptr = 0.
- req_ready during reset is 0.
- Reset deasserting mid-stream: in-flight channel contents are discarded and arbitration restarts from unit 0.
- flush and reset_n both active: reset dominates.
- All units requesting, with NUM_CHANNELS = NUM_UNITS: every unit is granted, and rr_ptr returns to its previous value.
- Only one requester: it lands on channel 0 regardless of its index.
- Illegal parameter combinations (NUM_CHANNELS > NUM_UNITS, or NUM_UNITS < 2) fail an elaboration-time check.

## Structure
- Package exec_unit_dtypes gains:
  - arb_mode_e (ARB_RR, ARB_FIXED);
  - a typedef for the channel record {valid, src, data}, parameterised by width through localparams in the module.
- Sub-module eu_icon_rr_scan:
  - purely combinational;
  - inputs: req vector and start index;
  - outputs: grant vector, per-channel unit index and assigned flags, and last granted index.
- eu_icon_arbiter holds rr_ptr, the channel registers and the flush/reset logic.

## Test plan
- Reset held, then released, with all requesting (4 units, 2 channels): ch_valid = 00 during reset. After the first edge, channel 0 = unit 0 and channel 1 = unit 1; then rr_ptr = 2, and the next cycle gives units 2 and 3.
- Units 1 and 3 requesting with rr_ptr = 2: unit 3 → channel 0, unit 1 → channel 1 (wrap); rr_ptr ← 2.
- A single requester, unit 3, with data 0xDEADBEEF: ch_valid = 01, ch_data[0] = 0xDEADBEEF, ch_src[0] = 3 one cycle later; rr_ptr ← 0.
- ARB_MODE = 1 with all requesting for 3 cycles: units 0 and 1 are granted every cycle, units 2 and 3 never; rr_ptr_o stays 0.
- flush pulsed while all units request: req_ready = 0000 that cycle, ch_valid = 00 next cycle, rr_ptr = 0.
- reset_n asserted mid-burst between edges: outputs clear immediately without a clock. A randomised soak (NUM_UNITS = 5, NUM_CHANNELS = 3) must show no payload lost or duplicated and every unit's wait ≤ 2 cycles.
